drive_indicator_odometer: RTL and testbench
===========================================

// Module: drive_indicator_odometer
// PURPOSE
//  Downstream consumer of the manual-driving controller's state[3:0] and answer[3:0] outputs.
//  Drives the turn-signal and reverse lamps, and keeps a 4-digit BCD mileage count.
//  The mileage accumulates while the car is moving forward or backward.
//  Outputs feed the LED bank and the 7-segment scan driver.
// PARAMETERS
//  BLINK_HALF  50_000_000   cycles per blink half-period (0.5 s at 100 MHz); >=2
//  MILE_TICKS  100_000_000  cycles of motion per mileage unit (1 s at 100 MHz); >=2
// PORTS
//  clk           in   1   100 MHz system clock
//  rst           in   1   asynchronous, active-low reset
//  state         in   4   one-hot: 0001 unstarting, 0010 starting, 0100 moving, 1000 power_off
//  answer        in   4   [3] right turn, [2] left turn, [1] backward, [0] forward
//  led_left      out  1   left turn lamp (blinking)
//  led_right     out  1   right turn lamp (blinking)
//  led_back      out  1   reverse lamp (steady)
//  mileage_bcd   out  16  4 BCD digits; [15:12] thousands ... [3:0] units
//  mileage_wrap  out  1   sticky flag: counter has wrapped from 9999 to 0000
// BEHAVIOUR
//  Reset
//  - All registers clear: state_q=0001, ans_q=0, blink_cnt=0, phase=1, tick_cnt=0.
//  - Every output is 0 after reset.
//  Input stage
//  - state and answer are registered into state_q and ans_q on every clk edge.
//  - All logic below uses state_q and ans_q only.
//  Invalid or power-off state
//  - Non-one-hot state_q is treated as unstarting.
//  - state_q==1000 (power_off): synchronously clear mileage_bcd, mileage_wrap and tick_cnt; force all LEDs to 0.
//  Blink generator
//  - turning = ans_q[3] | ans_q[2].
//  - While turning: blink_cnt increments. At BLINK_HALF-1 it returns to 0 and phase toggles.
//  - While not turning: blink_cnt=0 and phase=1. The next turn therefore starts with the lamp ON.
//  - Both turn bits set: both lamps blink in phase.
//  Lamp outputs (registered)
//  - led_left <= ans_q[2] & phase.
//  - led_right <= ans_q[3] & phase.
//  - led_back <= ans_q[1].
//  - Latency: answer edge -> lamp change is 2 clk edges.
//  Odometer
//  - motion = (state_q==0100) & (ans_q[0] | ans_q[1]).
//  - While motion: tick_cnt increments. At MILE_TICKS-1 it returns to 0 and mileage increments by 1 in BCD with digit carry.
//  - While not motion (stop or leaving moving): tick_cnt holds its value. Partial units are kept, not lost.
//  - 9999 + 1 -> 0000 and mileage_wrap <= 1. mileage_wrap stays set until power_off or reset.
//  - Forward and backward motion both add to the count; the count never decrements.
//  Priority and reset
//  - power_off clear has priority over a same-cycle increment.
//  - Reset mid-count discards tick_cnt and mileage immediately (asynchronous).
// TESTING (BLINK_HALF=4, MILE_TICKS=5)
//  1. Reset low, then high with state=0001, answer=0 -> all outputs 0, mileage_bcd=16'h0000.
//  2. state=0100, answer=0101 held -> led_left=1 two edges later; toggles every 4 cycles; led_right=0.
//  3. state=0100, answer=0001 for 50 cycles -> mileage_bcd=16'h0010.
//  4. Motion 3 cycles, pause 10 cycles, motion 2 cycles -> mileage_bcd=16'h0001.
//  5. Preload to 9999 via long run, then 5 more motion cycles -> mileage_bcd=16'h0000, mileage_wrap=1.
//  6. state=1000 while answer=0110 -> all LEDs 0, mileage_bcd=0, mileage_wrap=0 two edges later.

Source files
------------

// File: rtl/drive_indicator_odometer.sv
// Turn/reverse lamp driver and 4-digit BCD odometer fed by the manual-driving
// controller's one-hot state and answer outputs.
module drive_indicator_odometer #(
  parameter int BLINK_HALF = 50_000_000,
  parameter int MILE_TICKS = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  state,
  input  logic [3:0]  answer,
  output logic        led_left,
  output logic        led_right,
  output logic        led_back,
  output logic [15:0] mileage_bcd,
  output logic        mileage_wrap
);

  localparam int BW = (BLINK_HALF > 2) ? $clog2(BLINK_HALF) : 1;
  localparam int TW = (MILE_TICKS > 2) ? $clog2(MILE_TICKS) : 1;

  typedef enum logic [1:0] {
    MODE_UNSTARTING,
    MODE_STARTING,
    MODE_MOVING,
    MODE_POWER_OFF
  } mode_t;

  logic [3:0]    state_q;
  logic [3:0]    ans_q;
  logic [BW-1:0] blink_cnt;
  logic          phase;
  logic [TW-1:0] tick_cnt;
  mode_t         mode;
  logic          turning;
  logic          motion;
  logic          blink_end;
  logic          tick_end;
  logic [15:0]   bcd_inc;
  logic          bcd_carry;

  // Input stage: everything downstream sees only the registered copies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= 4'b0001;
      ans_q   <= 4'b0000;
    end else begin
      state_q <= state;
      ans_q   <= answer;
    end
  end

  // Any pattern that is not exactly one-hot falls back to unstarting.
  always_comb begin
    mode = MODE_UNSTARTING;
    case (state_q)
      4'b0001: mode = MODE_UNSTARTING;
      4'b0010: mode = MODE_STARTING;
      4'b0100: mode = MODE_MOVING;
      4'b1000: mode = MODE_POWER_OFF;
      default: mode = MODE_UNSTARTING;
    endcase
  end

  assign turning   = ans_q[3] | ans_q[2];
  assign motion    = (mode == MODE_MOVING) & (ans_q[0] | ans_q[1]);
  assign blink_end = (blink_cnt == BW'(BLINK_HALF - 1));
  assign tick_end  = (tick_cnt == TW'(MILE_TICKS - 1));

  // Idle parks the phase high so every new turn starts with the lamp lit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (turning) begin
      if (blink_end) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end else begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_left  <= 1'b0;
      led_right <= 1'b0;
      led_back  <= 1'b0;
    end else if (mode == MODE_POWER_OFF) begin
      led_left  <= 1'b0;
      led_right <= 1'b0;
      led_back  <= 1'b0;
    end else begin
      led_left  <= ans_q[2] & phase;
      led_right <= ans_q[3] & phase;
      led_back  <= ans_q[1];
    end
  end

  // Ripple BCD increment; the carry out of the thousands digit marks a wrap.
  always_comb begin
    logic carry;
    bcd_inc = mileage_bcd;
    carry   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (mileage_bcd[4*i +: 4] == 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = mileage_bcd[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    bcd_carry = carry;
  end

  // Tick count only holds while stationary so partial units survive a stop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt     <= '0;
      mileage_bcd  <= 16'h0000;
      mileage_wrap <= 1'b0;
    end else if (mode == MODE_POWER_OFF) begin
      tick_cnt     <= '0;
      mileage_bcd  <= 16'h0000;
      mileage_wrap <= 1'b0;
    end else if (motion) begin
      if (tick_end) begin
        tick_cnt    <= '0;
        mileage_bcd <= bcd_inc;
        if (bcd_carry) begin
          mileage_wrap <= 1'b1;
        end
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

endmodule

// File: tb/tb_drive_indicator_odometer.sv
// Table-driven scoreboard bench for drive_indicator_odometer with short
// blink/mileage periods so every corner fits in a few hundred cycles.
module tb_drive_indicator_odometer;

  logic        clk;
  logic        rst;
  logic [3:0]  state;
  logic [3:0]  answer;
  logic        led_left;
  logic        led_right;
  logic        led_back;
  logic [15:0] mileage_bcd;
  logic        mileage_wrap;

  int n_tests;
  int n_failed;

  typedef struct {
    bit          rst_first;
    logic [3:0]  state;
    logic [3:0]  answer;
    int          cycles;
    logic        left;
    logic        right;
    logic        back;
    logic [15:0] bcd;
    logic        wrap;
  } vec_t;

  vec_t vecs[$];
  vec_t expected_q[$];

  drive_indicator_odometer #(
    .BLINK_HALF(4),
    .MILE_TICKS(5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .state        (state),
    .answer       (answer),
    .led_left     (led_left),
    .led_right    (led_right),
    .led_back     (led_back),
    .mileage_bcd  (mileage_bcd),
    .mileage_wrap (mileage_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(bit rf, logic [3:0] st, logic [3:0] an, int cyc,
                              logic l, logic r, logic b, logic [15:0] bcd, logic w);
    vec_t v;
    v.rst_first = rf;
    v.state     = st;
    v.answer    = an;
    v.cycles    = cyc;
    v.left      = l;
    v.right     = r;
    v.back      = b;
    v.bcd       = bcd;
    v.wrap      = w;
    return v;
  endfunction

  task automatic check_field(string name, int idx, logic [15:0] got, logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b0;
    state  = 4'b0001;
    answer = 4'b0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Drive one record, let it run its cycle count, queue what it should produce.
  task automatic apply_stimulus(vec_t v);
    if (v.rst_first) do_reset();
    state  = v.state;
    answer = v.answer;
    expected_q.push_back(v);
    repeat (v.cycles) @(negedge clk);
  endtask

  task automatic check_output(int idx);
    vec_t e;
    if (expected_q.size() == 0) begin
      n_tests++;
      n_failed++;
      $display("[TB] FAIL scoreboard step %0d: got empty queue expected one entry", idx);
    end else begin
      e = expected_q.pop_front();
      check_field("led_left",     idx, {15'd0, led_left},     {15'd0, e.left});
      check_field("led_right",    idx, {15'd0, led_right},    {15'd0, e.right});
      check_field("led_back",     idx, {15'd0, led_back},     {15'd0, e.back});
      check_field("mileage_bcd",  idx, mileage_bcd,           e.bcd);
      check_field("mileage_wrap", idx, {15'd0, mileage_wrap}, {15'd0, e.wrap});
    end
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst      = 1'b0;
    state    = 4'b0001;
    answer   = 4'b0000;

    // Reset state
    vecs.push_back(mk(1, 4'b0001, 4'b0000, 2,  0, 0, 0, 16'h0000, 0));
    // Left turn while moving forward: 2-edge latency, 4-cycle half period
    vecs.push_back(mk(0, 4'b0100, 4'b0101, 1,  0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0101, 1,  1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0101, 3,  1, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0101, 1,  0, 0, 0, 16'h0001, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0101, 3,  0, 0, 0, 16'h0001, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0101, 1,  1, 0, 0, 16'h0001, 0));
    // 50 forward cycles give 10 units with digit carry
    vecs.push_back(mk(1, 4'b0100, 4'b0001, 50, 0, 0, 0, 16'h0009, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 2,  0, 0, 0, 16'h0010, 0));
    // Backward 3, pause 10, backward 2: partial unit kept across the pause
    vecs.push_back(mk(1, 4'b0100, 4'b0010, 3,  0, 0, 1, 16'h0000, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 10, 0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0010, 2,  0, 0, 1, 16'h0000, 0));
    vecs.push_back(mk(0, 4'b0100, 4'b0000, 2,  0, 0, 0, 16'h0001, 0));
    // Both turn bits in starting state blink together, no mileage
    vecs.push_back(mk(1, 4'b0010, 4'b1100, 2,  1, 1, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 4'b0010, 4'b1100, 3,  1, 1, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 4'b0010, 4'b1100, 1,  0, 0, 0, 16'h0000, 0));
    // Stop turning, then a new right turn starts lit
    vecs.push_back(mk(0, 4'b0010, 4'b0000, 2,  0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 4'b0010, 4'b1000, 2,  0, 1, 0, 16'h0000, 0));
    // Non-one-hot state counts as unstarting: no mileage
    vecs.push_back(mk(0, 4'b0110, 4'b0001, 6,  0, 0, 0, 16'h0000, 0));
    // Power-off clears two edges after it is applied
    vecs.push_back(mk(1, 4'b0100, 4'b0010, 11, 0, 0, 1, 16'h0002, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b0110, 1,  0, 0, 1, 16'h0002, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b0110, 1,  0, 0, 0, 16'h0000, 0));
    vecs.push_back(mk(0, 4'b1000, 4'b0110, 3,  0, 0, 0, 16'h0000, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i]);
      check_output(i);
    end

    // Wrap: 9999 units, then one more, then power-off clears the sticky flag
    apply_stimulus(mk(1, 4'b0100, 4'b0001, 49996, 0, 0, 0, 16'h9999, 0));
    check_output(100);
    apply_stimulus(mk(0, 4'b0100, 4'b0001, 5, 0, 0, 0, 16'h0000, 1));
    check_output(101);
    apply_stimulus(mk(0, 4'b0100, 4'b0000, 3, 0, 0, 0, 16'h0000, 1));
    check_output(102);
    apply_stimulus(mk(0, 4'b1000, 4'b0110, 2, 0, 0, 0, 16'h0000, 0));
    check_output(103);

    // Asynchronous reset mid-count discards both mileage and partial ticks
    apply_stimulus(mk(1, 4'b0100, 4'b0001, 7, 0, 0, 0, 16'h0001, 0));
    check_output(200);
    rst = 1'b0;
    #1;
    check_field("async_rst_bcd", 201, mileage_bcd, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(mk(0, 4'b0100, 4'b0001, 5, 0, 0, 0, 16'h0000, 0));
    check_output(202);
    apply_stimulus(mk(0, 4'b0100, 4'b0000, 2, 0, 0, 0, 16'h0001, 0));
    check_output(203);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
